// File: rtl/fifo_uart_pkg.sv
// Shared state encoding and parameter limits for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned STOP_BITS_MIN    = 1;
    localparam int unsigned STOP_BITS_MAX    = 2;
    localparam int unsigned CLKS_PER_BIT_MIN = 2;
    localparam int unsigned DSIZE_MIN        = 1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_bit_timer
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end,
    output logic bit_end_next_c
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_cpb
        $error("uart_bit_timer: CLKS_PER_BIT below minimum");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end        = (cnt_q == CW'(CLKS_PER_BIT - 1));
    // Lookahead lets the parent register a pulse that lands on the last cycle.
    assign bit_end_next_c = (cnt_d == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word per frame and sends it LSB first on txd.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DSIZE        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic             txd,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned BCW = $clog2(DSIZE + STOP_BITS + 1);

    if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_cpb
        $error("fifo_uart_tx: CLKS_PER_BIT below minimum");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
        $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DSIZE < DSIZE_MIN) begin : g_bad_dsize
        $error("fifo_uart_tx: DSIZE must be at least 1");
    end

    uart_state_e      state_q, state_d;
    logic [DSIZE-1:0] sreg_q, sreg_d;
    logic             par_q, par_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;
    logic             bit_end_next_c;
    logic             last_data;
    logic             last_stop;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk            (clk),
        .rst            (rst),
        .restart        (state_q == IDLE),
        .bit_end        (bit_end),
        .bit_end_next_c (bit_end_next_c)
    );

    assign rinc       = (state_q == IDLE) && !rempty && !rst;
    assign last_data  = (bcnt_q == BCW'(DSIZE - 1));
    assign last_stop  = (bcnt_q == BCW'(STOP_BITS - 1));
    assign txd        = txd_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // Next-state, datapath and registered-output lookahead.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        par_d   = par_q;
        bcnt_d  = bcnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rinc) begin
                    sreg_d  = rdata;
                    par_d   = ^rdata;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (last_data) begin
                        bcnt_d  = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bcnt_d = bcnt_q + BCW'(1);
                        sreg_d = sreg_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                done_d = last_stop && bit_end_next_c;
                if (bit_end) begin
                    if (last_stop) begin
                        bcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        bcnt_d = bcnt_q + BCW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = sreg_d[0];
            PARITY:  txd_d = par_d;
            default: txd_d = 1'b1;
        endcase

        // A non-empty FIFO at frame end guarantees a pop in the following IDLE cycle.
        busy_d = (state_d != IDLE) || ((state_q == STOP) && !rempty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            par_q   <= 1'b0;
            bcnt_q  <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            par_q   <= par_d;
            bcnt_q  <= bcnt_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two configurations fed by small fall-through FIFO models.
module tb_fifo_uart_tx;

    localparam int unsigned DW  = 8;
    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] rdata_a = '0;
    logic [DW-1:0] rdata_b = '0;
    logic          rempty_a = 1'b1;
    logic          rempty_b = 1'b1;
    logic          rinc_a, rinc_b, txd_a, txd_b, busy_a, busy_b, fd_a, fd_b;

    fifo_uart_tx #(.DSIZE(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rdata(rdata_a), .rempty(rempty_a), .rinc(rinc_a),
        .txd(txd_a), .busy(busy_a), .frame_done(fd_a)
    );

    fifo_uart_tx #(.DSIZE(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rdata(rdata_b), .rempty(rempty_b), .rinc(rinc_b),
        .txd(txd_b), .busy(busy_b), .frame_done(fd_b)
    );

    // FIFO models: the bench writes mem/wr, the model owns rd and the registered flags.
    logic [DW-1:0] mem_a [0:31];
    logic [DW-1:0] mem_b [0:31];
    logic [4:0]    wr_a = '0, rd_a = '0, wr_b = '0, rd_b = '0;
    bit            scramble = 1'b0;

    always @(posedge clk) begin : p_fifo
        logic [4:0] na, nb;
        na = rd_a + 5'(rinc_a);
        nb = rd_b + 5'(rinc_b);
        rd_a     <= na;
        rd_b     <= nb;
        rempty_a <= (na == wr_a);
        rempty_b <= (nb == wr_b);
        rdata_a  <= (na != wr_a) ? mem_a[na] : (scramble ? DW'($urandom) : '0);
        rdata_b  <= (nb != wr_b) ? mem_b[nb] : '0;
    end

    int cyc = 0;
    int rinc_cnt_a = 0, fd_cnt_a = 0, fd_cnt_b = 0, fd_cyc_a = 0, fd_cyc_b = 0;
    int rinc_cyc_a[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rinc_a) begin
            rinc_cnt_a <= rinc_cnt_a + 1;
            rinc_cyc_a.push_back(cyc);
        end
        if (fd_a) begin
            fd_cnt_a <= fd_cnt_a + 1;
            fd_cyc_a <= cyc;
        end
        if (fd_b) begin
            fd_cnt_b <= fd_cnt_b + 1;
            fd_cyc_b <= cyc;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic tx(input bit sel);
        return sel ? txd_b : txd_a;
    endfunction

    task automatic push_a(input logic [DW-1:0] v);
        mem_a[wr_a] = v;
        wr_a = wr_a + 5'd1;
    endtask

    task automatic push_b(input logic [DW-1:0] v);
        mem_b[wr_b] = v;
        wr_b = wr_b + 5'd1;
    endtask

    // Waits for the start bit, then samples each bit slot mid-period; bit 0 is the start bit.
    task automatic capture(input bit sel, input int nslots, output logic [15:0] bits, output int fall);
        int t;
        bits = '0;
        t = 0;
        while (tx(sel) !== 1'b0 && t < 400) begin
            step();
            t++;
        end
        fall = cyc;
        check(sel ? "b_start_found" : "a_start_found", 32'(t < 400), 32'd1);
        step(2);
        for (int i = 0; i < nslots; i++) begin
            bits = bits | (16'(tx(sel)) << i);
            if (i != nslots - 1) step(CPB);
        end
    endtask

    task automatic wait_done(input bit sel, input int prev);
        int t;
        t = 0;
        while ((sel ? fd_cnt_b : fd_cnt_a) == prev && t < 200) begin
            step();
            t++;
        end
        check(sel ? "b_frame_done_seen" : "a_frame_done_seen", 32'(t < 200), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] bits;
        logic [7:0]  words [0:2];
        int          fall, base, bad, cnt0, fd0;

        words[0] = 8'h01;
        words[1] = 8'h80;
        words[2] = 8'h55;

        // Reset values
        rst = 1'b1;
        step(3);
        check("rst_txd", 32'(txd_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_frame_done", 32'(fd_a), 32'd0);
        check("rst_rinc", 32'(rinc_a), 32'd0);
        check("rst_txd_b", 32'(txd_b), 32'd1);
        push_a(8'hA5);
        step(2);
        check("rinc_gated_by_rst", 32'(rinc_a), 32'd0);

        // Single word A5, 8N1
        rst = 1'b0;
        #1;
        check("rinc_comb_after_rst", 32'(rinc_a), 32'd1);
        capture(1'b0, 10, bits, fall);
        check("a5_bits", 32'(bits[9:0]), 32'({1'b1, 8'hA5, 1'b0}));
        check("pop_to_fall_latency", 32'(fall - rinc_cyc_a[0]), 32'd1);
        wait_done(1'b0, 0);
        check("a5_frame_len", 32'(fd_cyc_a - fall + 1), 32'd40);
        check("a5_busy_after", 32'(busy_a), 32'd0);
        check("a5_txd_after", 32'(txd_a), 32'd1);
        step(3);
        check("a5_single_pop", 32'(rinc_cnt_a), 32'd1);

        // Even parity, two stop bits
        push_b(8'hA5);
        push_b(8'h07);
        capture(1'b1, 12, bits, fall);
        check("par_a5_bits", 32'(bits[11:0]), 32'({2'b11, 1'b0, 8'hA5, 1'b0}));
        wait_done(1'b1, 0);
        check("par_a5_len", 32'(fd_cyc_b - fall + 1), 32'd48);
        capture(1'b1, 12, bits, fall);
        check("par_07_bits", 32'(bits[11:0]), 32'({2'b11, 1'b1, 8'h07, 1'b0}));
        wait_done(1'b1, 1);
        check("par_07_len", 32'(fd_cyc_b - fall + 1), 32'd48);

        // Back-to-back frames
        base = rinc_cnt_a;
        push_a(words[0]);
        push_a(words[1]);
        push_a(words[2]);
        for (int j = 0; j < 3; j++) begin
            fd0 = fd_cnt_a;
            capture(1'b0, 10, bits, fall);
            check("b2b_bits", 32'(bits[9:0]), 32'({1'b1, words[j], 1'b0}));
            wait_done(1'b0, fd0);
            check("b2b_busy_gap", 32'(busy_a), (j < 2) ? 32'd1 : 32'd0);
        end
        step(2);
        check("b2b_pop_count", 32'(rinc_cnt_a - base), 32'd3);
        check("b2b_spacing_1", 32'(rinc_cyc_a[base + 1] - rinc_cyc_a[base]), 32'd41);
        check("b2b_spacing_2", 32'(rinc_cyc_a[base + 2] - rinc_cyc_a[base + 1]), 32'd41);

        // Empty FIFO idles quietly
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (rinc_a !== 1'b0 || txd_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check("empty_idle_violations", 32'(bad), 32'd0);
        push_a(8'h3C);
        step();
        check("pop_after_write", 32'(rinc_a), 32'd1);
        fd0 = fd_cnt_a;
        capture(1'b0, 10, bits, fall);
        check("3c_bits", 32'(bits[9:0]), 32'({1'b1, 8'h3C, 1'b0}));
        wait_done(1'b0, fd0);

        // Reset during data bit 3
        push_a(8'hC3);
        fd0 = fd_cnt_a;
        capture(1'b0, 5, bits, fall);
        check("c3_partial_bits", 32'(bits[4:0]), 32'(5'b00110));
        cnt0 = rinc_cnt_a;
        push_a(8'h96);
        rst = 1'b1;
        step();
        check("midrst_txd", 32'(txd_a), 32'd1);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_rinc", 32'(rinc_a), 32'd0);
        step(2);
        check("midrst_rinc_held", 32'(rinc_a), 32'd0);
        check("midrst_no_pop", 32'(rinc_cnt_a - cnt0), 32'd0);
        rst = 1'b0;
        capture(1'b0, 10, bits, fall);
        check("96_bits", 32'(bits[9:0]), 32'({1'b1, 8'h96, 1'b0}));
        wait_done(1'b0, fd0);
        check("96_len", 32'(fd_cyc_a - fall + 1), 32'd40);
        check("96_one_pop", 32'(rinc_cnt_a - cnt0), 32'd1);

        // rdata churns while the frame is in flight
        scramble = 1'b1;
        push_a(8'h5A);
        fd0 = fd_cnt_a;
        capture(1'b0, 10, bits, fall);
        check("5a_stable_bits", 32'(bits[9:0]), 32'({1'b1, 8'h5A, 1'b0}));
        wait_done(1'b0, fd0);
        scramble = 1'b0;

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
